// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
// Data-memory bus between the MEM stage (master) and the data memory (slave).
//   dmem_req   : master -> slave, access request (held for the whole access)
//   dmem_we    : master -> slave, 1 = write, 0 = read
//   dmem_addr  : master -> slave, word-aligned byte address
//   dmem_wdata : master -> slave, lane-replicated store data
//   dmem_be    : master -> slave, byte enables (0000 for reads)
//   dmem_ready : slave -> master, access accepted/completed this cycle
//   dmem_rdata : slave -> master, raw 32-bit read word
// -----------------------------------------------------------------------------
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// MEM pipeline stage: resolves the actual next PC (mispredict detection) and
// performs data-memory loads/stores over a req/ready bus with a timeout.
//
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   *_MEM (32-bit)           : EX/MEM register contents (ALU_result = address,
//                              read_data_2 = store data, inst[14:12] = funct3)
//   *_flag_MEM               : EX/MEM control bits
//   dmem (master)            : data-memory bus, see mem_access_unit_if
//   stall_MEM                : freezes the upstream pipeline
//   wrong_prediction_flag    : flush request, redirect_pc = actual next PC
//   load_data_MEM            : formatted load result for MEM/WB
//   mem_err                  : sticky error (misaligned access or timeout)
//
// Build option: define MEM_ACCESS_MMIO_EN to add io_addr/io_we/io_wdata/
// io_rdata; word addresses >= 0xFFFFFC00 then complete in one cycle on the
// io port without stalling or touching dmem.
// -----------------------------------------------------------------------------
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALU_result_MEM,
  input  logic [31:0] imme_MEM,
  input  logic [31:0] read_data_1_MEM,
  input  logic [31:0] read_data_2_MEM,
  input  logic [31:0] inst_MEM,
  input  logic [31:0] pc_MEM,
  input  logic [31:0] pc_prediction_MEM,
  input  logic        zero_flag_MEM,
  input  logic        branch_flag_MEM,
  input  logic        jal_flag_MEM,
  input  logic        jalr_flag_MEM,
  input  logic        mem_write_flag_MEM,
  input  logic        mem_to_reg_flag_MEM,
  input  logic        reg_write_flag_MEM,
  mem_access_unit_if.master dmem,
  output logic        stall_MEM,
  output logic        wrong_prediction_flag,
  output logic [31:0] redirect_pc,
  output logic [31:0] load_data_MEM,
  output logic        mem_err
`ifdef MEM_ACCESS_MMIO_EN
  ,
  output logic [31:0] io_addr,
  output logic        io_we,
  output logic [31:0] io_wdata,
  input  logic [31:0] io_rdata
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic [31:0] load_data_q, load_data_d;
  logic        mem_err_q, mem_err_d;

  logic [2:0]  funct3;
  logic [1:0]  ofs;
  logic        mem_op;
  logic        misaligned;
  logic        is_mmio;
  logic [31:0] actual_pc;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic        unused_ok;

  assign unused_ok = reg_write_flag_MEM;

  assign funct3 = inst_MEM[14:12];
  assign ofs    = ALU_result_MEM[1:0];
  assign mem_op = mem_to_reg_flag_MEM | mem_write_flag_MEM;

`ifdef MEM_ACCESS_MMIO_EN
  assign is_mmio = &ALU_result_MEM[31:10];
`else
  assign is_mmio = 1'b0;
`endif

  // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always fine.
  always_comb begin
    unique case (funct3[1:0])
      2'b01:   misaligned = ofs[0];
      2'b10:   misaligned = (ofs != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  // NOTE: every signal driven in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    actual_pc = pc_MEM + 32'd4;
    if (jal_flag_MEM)                       actual_pc = pc_MEM + imme_MEM;
    else if (jalr_flag_MEM)                 actual_pc = (read_data_1_MEM + imme_MEM) & ~32'd1;
    else if (branch_flag_MEM && zero_flag_MEM) actual_pc = pc_MEM + imme_MEM;
  end

  assign redirect_pc = actual_pc;
  assign wrong_prediction_flag = (inst_MEM != 32'd0) && !stall_MEM &&
                                 (actual_pc != pc_prediction_MEM);

  // Store data is replicated across all lanes; byte enables pick the lane.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = read_data_2_MEM;
    unique case (funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << ofs;
        st_wdata = {4{read_data_2_MEM[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << ofs;
        st_wdata = {2{read_data_2_MEM[15:0]}};
      end
      default: ;
    endcase
  end

  function automatic logic [31:0] fmt_load(input logic [2:0] f3,
                                           input logic [1:0] a,
                                           input logic [31:0] raw);
    logic [31:0] sh;
    sh = raw >> {a, 3'b000};
    unique case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'd0, sh[7:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return raw;
    endcase
  endfunction

  assign dmem.dmem_addr  = {ALU_result_MEM[31:2], 2'b00};
  assign dmem.dmem_wdata = st_wdata;

`ifdef MEM_ACCESS_MMIO_EN
  assign io_addr  = {ALU_result_MEM[31:2], 2'b00};
  assign io_wdata = st_wdata;
  assign io_we    = (state_q == S_IDLE) && mem_write_flag_MEM && is_mmio && !misaligned;
`endif

  always_comb begin
    state_d       = state_q;
    tmo_cnt_d     = tmo_cnt_q;
    load_data_d   = load_data_q;
    mem_err_d     = mem_err_q;
    stall_MEM     = 1'b0;
    dmem.dmem_req = 1'b0;
    dmem.dmem_we  = 1'b0;
    dmem.dmem_be  = 4'b0000;
    unique case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          if (misaligned) begin
            mem_err_d = 1'b1;
          end else if (is_mmio) begin
`ifdef MEM_ACCESS_MMIO_EN
            if (mem_to_reg_flag_MEM) load_data_d = fmt_load(funct3, ofs, io_rdata);
`endif
          end else begin
            state_d   = S_WAIT;
            tmo_cnt_d = 8'd0;
            stall_MEM = 1'b1;
          end
        end
      end
      S_WAIT: begin
        stall_MEM     = 1'b1;
        dmem.dmem_req = 1'b1;
        dmem.dmem_we  = mem_write_flag_MEM;
        dmem.dmem_be  = mem_write_flag_MEM ? st_be : 4'b0000;
        tmo_cnt_d     = tmo_cnt_q + 8'd1;
        if (dmem.dmem_ready) begin
          state_d = S_DONE;
          if (mem_to_reg_flag_MEM) load_data_d = fmt_load(funct3, ofs, dmem.dmem_rdata);
        end else if (tmo_cnt_q == 8'd254) begin
          // The count reaches 255 at the end of this, the 255th, WAIT cycle.
          state_d   = S_DONE;
          mem_err_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      tmo_cnt_q   <= 8'd0;
      load_data_q <= 32'd0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_cnt_q   <= tmo_cnt_d;
      load_data_q <= load_data_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign load_data_MEM = load_data_q;
  assign mem_err       = mem_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Self-checking bench for mem_access_unit (default build, no MMIO). A simple
// memory responder raises dmem_ready in a chosen WAIT cycle; expected values
// come from a byte-lane reference model kept here.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu, imme, rd1, rd2, inst, pc, pred;
  logic        zero_f, br_f, jal_f, jalr_f, mw_f, m2r_f, rw_f;
  logic        stall, wp, mem_err;
  logic [31:0] redirect, load_data;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_load = 32'd0;
  logic        model_err  = 1'b0;

  mem_access_unit_if bus ();

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk                   (clk),
    .rst                   (rst),
    .ALU_result_MEM        (alu),
    .imme_MEM              (imme),
    .read_data_1_MEM       (rd1),
    .read_data_2_MEM       (rd2),
    .inst_MEM              (inst),
    .pc_MEM                (pc),
    .pc_prediction_MEM     (pred),
    .zero_flag_MEM         (zero_f),
    .branch_flag_MEM       (br_f),
    .jal_flag_MEM          (jal_f),
    .jalr_flag_MEM         (jalr_f),
    .mem_write_flag_MEM    (mw_f),
    .mem_to_reg_flag_MEM   (m2r_f),
    .reg_write_flag_MEM    (rw_f),
    .dmem                  (bus),
    .stall_MEM             (stall),
    .wrong_prediction_flag (wp),
    .redirect_pc           (redirect),
    .load_data_MEM         (load_data),
    .mem_err               (mem_err)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_next_pc(input logic j, input logic jr, input logic b,
                                            input logic z, input logic [31:0] p,
                                            input logic [31:0] im, input logic [31:0] r1);
    logic [31:0] t;
    if (j) return p + im;
    if (jr) begin
      t = r1 + im;
      t[0] = 1'b0;
      return t;
    end
    if (b && z) return p + im;
    return p + 32'd4;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] a,
                                         input logic [31:0] w);
    logic [7:0] b [4];
    int idx;
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    idx = int'(a);
    case (f3)
      3'd0:    return {{24{b[idx][7]}}, b[idx]};
      3'd1:    return {{16{b[idx+1][7]}}, b[idx+1], b[idx]};
      3'd4:    return {24'd0, b[idx]};
      3'd5:    return {16'd0, b[idx+1], b[idx]};
      default: return w;
    endcase
  endfunction

  task automatic m_store(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] d,
                         output logic [3:0] be, output logic [31:0] wd);
    int size;
    size = 1 << f3[1:0];
    for (int i = 0; i < 4; i++) begin
      be[i]       = (i >= int'(a)) && (i < int'(a) + size);
      wd[8*i +: 8] = d[8*(i % size) +: 8];
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_nop();
    alu = 0; imme = 0; rd1 = 0; rd2 = 0; inst = 0; pc = 0; pred = 0;
    zero_f = 0; br_f = 0; jal_f = 0; jalr_f = 0; mw_f = 0; m2r_f = 0; rw_f = 0;
    bus.dmem_ready = 1'b0;
    bus.dmem_rdata = 32'd0;
  endtask

  // One memory instruction; ready_at is the WAIT cycle (1-based) that sees
  // dmem_ready, a value above 255 means the memory never answers.
  task automatic run_mem(input string name, input logic is_store, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] rdata, input int ready_at);
    int stalls, waits, cycles, exp_stalls, exp_waits;
    logic exp_mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    exp_mis = (f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    if (exp_mis) begin
      exp_stalls = 0;
      model_err  = 1'b1;
    end else if (ready_at <= 255) begin
      exp_stalls = 1 + ready_at;
      if (!is_store) model_load = m_load(f3, addr[1:0], rdata);
    end else begin
      exp_stalls = 256;
      model_err  = 1'b1;
    end
    exp_waits = (exp_stalls == 0) ? 0 : exp_stalls - 1;
    if (is_store) m_store(f3, addr[1:0], data, exp_be, exp_wd);
    else begin exp_be = 4'b0000; exp_wd = 32'd0; end

    @(negedge clk);
    alu = addr; rd2 = data; mw_f = is_store; m2r_f = !is_store; rw_f = !is_store;
    inst = {17'd0, f3, 5'd1, is_store ? 7'b0100011 : 7'b0000011};
    pc = 32'h0000_1000; pred = 32'h0000_1004;
    stalls = 0; waits = 0; cycles = 0;
    while (cycles < 400) begin
      #1;
      if (bus.dmem_req) begin
        waits++;
        bus.dmem_ready = (waits == ready_at);
        bus.dmem_rdata = (waits == ready_at) ? rdata : $urandom;
        if (waits == 1) begin
          checks++;
          if (bus.dmem_addr !== {addr[31:2], 2'b00}) begin
            failures++;
            $display("FAIL %s addr: got %h want %h", name, bus.dmem_addr, {addr[31:2], 2'b00});
          end
          checks++;
          if (bus.dmem_we !== is_store || bus.dmem_be !== exp_be) begin
            failures++;
            $display("FAIL %s we/be: got %b/%b want %b/%b", name, bus.dmem_we, bus.dmem_be, is_store, exp_be);
          end
          if (is_store) begin
            checks++;
            if (bus.dmem_wdata !== exp_wd) begin
              failures++;
              $display("FAIL %s wdata: got %h want %h", name, bus.dmem_wdata, exp_wd);
            end
          end
        end
      end else begin
        // Ready outside WAIT must have no effect.
        bus.dmem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      if (stall) stalls++;
      else break;
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (cycles >= 400) begin
      failures++;
      $display("FAIL %s timeout: stall never dropped within 400 cycles", name);
    end
    checks++;
    if (stalls !== exp_stalls || waits !== exp_waits) begin
      failures++;
      $display("FAIL %s stall/wait cycles: got %0d/%0d want %0d/%0d", name, stalls, waits, exp_stalls, exp_waits);
    end
    checks++;
    if (load_data !== model_load) begin
      failures++;
      $display("FAIL %s load_data: got %h want %h", name, load_data, model_load);
    end
    @(posedge clk);
    #1;
    set_nop();
    checks++;
    if (mem_err !== model_err) begin
      failures++;
      $display("FAIL %s mem_err: got %b want %b", name, mem_err, model_err);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_nop();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus.dmem_req, bus.dmem_we, bus.dmem_be, stall, mem_err} !== 8'd0 || load_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: req=%b we=%b be=%b stall=%b err=%b load=%h want all 0",
               bus.dmem_req, bus.dmem_we, bus.dmem_be, stall, mem_err, load_data);
    end
    rst = 1'b1;
    model_load = 0; model_err = 0;
    @(negedge clk);
  endtask

  task automatic test_directed_mem();
    run_mem("lw_0x100", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2);
    checks++;
    if (load_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL lw_const: got %h want deadbeef", load_data);
    end
    run_mem("lb_0x103", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 1);
    checks++;
    if (load_data !== 32'hFFFFFF80) begin
      failures++;
      $display("FAIL lb_const: got %h want ffffff80", load_data);
    end
    run_mem("lbu_0x103", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 3);
    checks++;
    if (load_data !== 32'h00000080) begin
      failures++;
      $display("FAIL lbu_const: got %h want 00000080", load_data);
    end
    run_mem("sh_0x102", 1'b1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 1);
  endtask

  task automatic test_sh_const();
    // Explicit constant look at the sh bus fields in the first WAIT cycle.
    @(negedge clk);
    alu = 32'h102; rd2 = 32'h0000ABCD; mw_f = 1'b1; inst = 32'h00001123;
    pc = 32'h2000; pred = 32'h2004;
    @(negedge clk);
    #1;
    checks++;
    if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b1 || bus.dmem_be !== 4'b1100 ||
        bus.dmem_wdata !== 32'hABCDABCD) begin
      failures++;
      $display("FAIL sh_const: req=%b we=%b be=%b wdata=%h want 1/1/1100/abcdabcd",
               bus.dmem_req, bus.dmem_we, bus.dmem_be, bus.dmem_wdata);
    end
    bus.dmem_ready = 1'b1;
    @(negedge clk);
    set_nop();
    @(negedge clk);
  endtask

  task automatic test_branch();
    logic [31:0] exp_pc;
    logic        exp_wp;
    @(negedge clk);
    inst = 32'h00000063; pc = 32'h40; imme = 32'h10; zero_f = 1; br_f = 1; pred = 32'h44;
    #1;
    checks++;
    if (wp !== 1'b1 || redirect !== 32'h50) begin
      failures++;
      $display("FAIL beq_mispredict: wp=%b redirect=%h want 1/00000050", wp, redirect);
    end
    pred = 32'h50;
    #1;
    checks++;
    if (wp !== 1'b0) begin
      failures++;
      $display("FAIL beq_correct: wp=%b want 0", wp);
    end
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      inst   = (n % 8 == 0) ? 32'd0 : 32'h00000063;
      pc     = $urandom & 32'hFFFF_FFFC;
      imme   = $urandom;
      rd1    = $urandom;
      jal_f  = 1'($urandom_range(0, 3) == 0);
      jalr_f = 1'($urandom_range(0, 3) == 0);
      br_f   = 1'($urandom_range(0, 1));
      zero_f = 1'($urandom_range(0, 1));
      exp_pc = m_next_pc(jal_f, jalr_f, br_f, zero_f, pc, imme, rd1);
      pred   = $urandom_range(0, 1) ? exp_pc : $urandom;
      exp_wp = (inst != 0) && (pred != exp_pc);
      #1;
      checks++;
      if (redirect !== exp_pc || wp !== exp_wp) begin
        failures++;
        $display("FAIL pc_rand%0d: redirect=%h wp=%b want %h/%b", n, redirect, wp, exp_pc, exp_wp);
      end
    end
    set_nop();
  endtask

  task automatic test_random_mem();
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    int          pick;
    for (int n = 0; n < 30; n++) begin
      st = 1'($urandom_range(0, 1));
      if (st) f3 = 3'($urandom_range(0, 2));
      else begin
        pick = $urandom_range(0, 4);
        f3   = (pick < 3) ? 3'(pick) : 3'(pick + 1);
      end
      a = $urandom & 32'h7FFF_FFFF;
      if (f3[1:0] == 2'b01) a[0] = 1'b0;
      if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      run_mem($sformatf("rand%0d", n), st, f3, a, $urandom, $urandom, $urandom_range(1, 4));
    end
  endtask

  task automatic test_timeout();
    run_mem("timeout_lw", 1'b0, 3'b010, 32'h300, 32'h0, 32'h12345678, 1000);
    run_mem("sticky_after_timeout", 1'b0, 3'b010, 32'h304, 32'h0, 32'hCAFEF00D, 1);
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    alu = 32'h200; m2r_f = 1'b1; inst = 32'h00002003; pc = 32'h3000; pred = 32'h3004;
    @(negedge clk);
    #1;
    checks++;
    if (bus.dmem_req !== 1'b1) begin
      failures++;
      $display("FAIL rst_wait_pre: req=%b want 1", bus.dmem_req);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.dmem_req !== 1'b0 || bus.dmem_we !== 1'b0 || bus.dmem_be !== 4'b0000 ||
        load_data !== 32'd0 || mem_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_wait_abort: req=%b we=%b be=%b load=%h err=%b want 0",
               bus.dmem_req, bus.dmem_we, bus.dmem_be, load_data, mem_err);
    end
    set_nop();
    model_load = 0; model_err = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.dmem_req !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL rst_wait_after: req=%b stall=%b want 0/0", bus.dmem_req, stall);
    end
  endtask

  task automatic test_misaligned();
    run_mem("lw_misaligned", 1'b0, 3'b010, 32'h102, 32'h0, 32'h11111111, 1);
    run_mem("sh_misaligned", 1'b1, 3'b001, 32'h201, 32'h5555, 32'h0, 1);
    run_mem("sticky_after_mis", 1'b0, 3'b101, 32'h402, 32'h0, 32'h9876FEDC, 2);
  endtask

  initial begin
    test_reset();
    test_directed_mem();
    test_sh_const();
    test_branch();
    test_random_mem();
    test_timeout();
    test_reset_in_wait();
    test_misaligned();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 clk  in  1  pipeline clock; all state changes on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 ALU_result_MEM/imme_MEM/read_data_1_MEM/read_data_2_MEM/inst_MEM/pc_MEM/pc_prediction_MEM  in  32 each  EX/MEM register contents; ALU_result is the effective address, read_data_2 is the store data.
REQ-004 zero_flag_MEM, branch_flag_MEM, jal_flag_MEM, jalr_flag_MEM, mem_write_flag_MEM, mem_to_reg_flag_MEM, reg_write_flag_MEM  in  1 each  control from EX/MEM; zero_flag=1 means the branch condition holds.
REQ-005 dmem_req  out 1; dmem_we  out 1; dmem_addr  out 32; dmem_wdata  out 32; dmem_be  out 4  data memory request.
REQ-006 dmem_ready  in 1; dmem_rdata  in 32  memory acceptance/completion and raw read word.
REQ-007 stall_MEM  out 1  freezes PC, IF/ID, ID/EX and EX/MEM when high.
REQ-008 wrong_prediction_flag  out 1; redirect_pc  out 32  mispredict flush and correct next PC.
REQ-009 load_data_MEM  out 32  formatted load result for MEM/WB; mem_err  out 1  sticky error flag.

Function
REQ-010 Actual next PC: jal -> pc+imme; jalr -> (read_data_1+imme) with bit0 cleared; branch_flag&zero_flag -> pc+imme; otherwise pc+4; 32-bit wrap-around.
REQ-011 wrong_prediction_flag SHALL be combinational: 1 iff inst_MEM!=0, stall_MEM=0 and actual next PC != pc_prediction_MEM; redirect_pc SHALL equal actual next PC at all times.
REQ-012 A memory op is present when mem_to_reg_flag_MEM or mem_write_flag_MEM is 1; funct3 = inst_MEM[14:12].
REQ-013 FSM states IDLE, WAIT, DONE: IDLE + aligned op -> WAIT; WAIT & dmem_ready -> DONE; DONE -> IDLE unconditionally.
REQ-014 dmem_req=1 in WAIT only; dmem_addr = {ALU_result[31:2],2'b00}; dmem_we = mem_write_flag in WAIT.
REQ-015 stall_MEM=1 in IDLE-with-aligned-op and in WAIT; stall_MEM=0 in DONE, so each access stalls at least 2 cycles.
REQ-016 Store: sb -> be=0001<<addr[1:0], byte replicated x4; sh -> be=0011<<addr[1:0], halfword replicated x2; sw -> be=1111; loads drive be=0000.
REQ-017 On WAIT & dmem_ready, load_data_MEM SHALL register dmem_rdata formatted: lb/lh sign-extend, lbu/lhu zero-extend, lw unchanged; byte/half selected by addr[1:0]; value held until the next load completes.
REQ-018 Misaligned (lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0) SHALL NOT enter WAIT, SHALL NOT stall or request, and SHALL set mem_err.
REQ-019 Timeout: an 8-bit counter clears on entry to WAIT and increments each WAIT cycle; at count 255 without dmem_ready the FSM SHALL go to DONE, set mem_err and leave load_data_MEM unchanged.
REQ-020 mem_err SHALL remain 1 until reset.
REQ-021 dmem_ready outside WAIT SHALL be ignored.

Reset
REQ-022 While rst=0: state=IDLE, timeout counter=0, load_data_MEM=0, mem_err=0, dmem_req=0, dmem_we=0, dmem_be=0.
REQ-023 Reset asserted in WAIT SHALL abort the access immediately; after release the FSM starts in IDLE with no request outstanding.

Configuration
REQ-024 With MEM_ACCESS_MMIO_EN defined, word addresses >= 0xFFFFFC00 SHALL be MMIO: ports io_addr(out 32), io_we(out 1), io_wdata(out 32), io_rdata(in 32) are added; the access completes in the current cycle with no stall and no dmem_req, and load_data_MEM registers the formatted io_rdata on the next edge.
REQ-025 Without MEM_ACCESS_MMIO_EN the io ports SHALL be absent and every address SHALL go to dmem.

Verification
REQ-026 lw at 0x100, dmem_ready=1 in the 2nd WAIT cycle, rdata=0xDEADBEEF -> stall_MEM high 3 cycles, load_data_MEM=0xDEADBEEF.
REQ-027 lb at 0x103, rdata=0x80112233 -> load_data_MEM=0xFFFFFF80; lbu at the same address -> 0x00000080.
REQ-028 sh at 0x102, data 0x0000ABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1 in WAIT.
REQ-029 beq pc=0x40, imme=0x10, zero=1, prediction 0x44 -> wrong_prediction_flag=1, redirect_pc=0x50; prediction 0x50 -> flag=0.
REQ-030 lw at 0x102 -> no stall, no dmem_req, mem_err=1 and it stays 1; dmem_ready held low for 300 cycles on an aligned lw -> DONE after 255 WAIT cycles, mem_err=1.
REQ-031 Reset pulsed in WAIT -> dmem_req=0 and state=IDLE immediately; load_data_MEM=0.
